launchpad_key_scheduler: RTL



---
 rtl/launchpad_key_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/launchpad_key_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : launchpad_key_scheduler
// Brief    : Synchronizes/debounces 12 pads, queues one 4-bit code per press.
// Revision : 1.0
// ============================================================================
module launchpad_key_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pad_in,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [11:0] key_held,
  output logic        any_key,
  output logic        fifo_full,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int                 c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]         c_cnt_max = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [11:0]        r_sync1;
  logic [11:0]        r_sync2;
  logic [7:0]         r_cnt [12];
  logic [11:0]        r_held;
  logic [11:0]        r_pend;
  logic               r_ovf;
  logic [3:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_count;

  logic [11:0] w_held_next;
  logic [11:0] w_rise;
  logic [11:0] w_sel_oh;
  logic [11:0] w_clr;
  logic [3:0]  w_sel;
  logic        w_pop;
  logic        w_push;
  logic        w_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
    end
  end

  // A pad flips its held level on the cycle its mismatch count reaches the limit.
  always_comb begin
    w_held_next = r_held;
    for (int i = 0; i < 12; i++) begin
      if ((r_sync2[i] != r_held[i]) && (r_cnt[i] == c_cnt_max)) begin
        w_held_next[i] = r_sync2[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) begin
        r_cnt[i] <= '0;
      end
      r_held <= '0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if ((r_sync2[i] == r_held[i]) || (r_cnt[i] == c_cnt_max)) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
      r_held <= w_held_next;
    end
  end

  assign w_rise = w_held_next & ~r_held;

  // Scan from the top so the lowest pending index is the one left selected.
  always_comb begin
    w_sel    = '0;
    w_sel_oh = '0;
    for (int i = 11; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel    = 4'(i);
        w_sel_oh = 12'b1 << i;
      end
    end
  end

  assign w_pop  = key_valid & key_ready;
  assign w_push = (|r_pend) & ((r_count < c_depth) | w_pop);
  assign w_clr  = w_push ? w_sel_oh : '0;
  assign w_lost = |(w_rise & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (w_lost) begin
        r_ovf <= 1'b1;
      end else if (clr_overflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (c_ptr_w + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (c_ptr_w + 1)'(1);
      end
    end
  end

  assign key_valid = (r_count != '0);
  assign key_code  = key_valid ? r_mem[r_rptr] : 4'd0;
  assign key_held  = r_held;
  assign any_key   = |r_held;
  assign fifo_full = (r_count == c_depth);
  assign overflow  = r_ovf;

endmodule
`default_nettype wire
